// File: rtl/div_unit_if.sv
// Handshake bundle between the execute stage and div_unit: operands and start/cancel in, busy/valid/HI/LO out.
interface div_unit_if #(parameter int DIV_W = 32);
    logic             div_start;
    logic             div_signed;
    logic [DIV_W-1:0] div_a;
    logic [DIV_W-1:0] div_b;
    logic             div_cancel;
    logic             div_busy;
    logic             div_valid;
    logic [DIV_W-1:0] div_hi;
    logic [DIV_W-1:0] div_lo;

    modport master (
        output div_start, div_signed, div_a, div_b, div_cancel,
        input  div_busy, div_valid, div_hi, div_lo
    );

    modport slave (
        input  div_start, div_signed, div_a, div_b, div_cancel,
        output div_busy, div_valid, div_hi, div_lo
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit DIV/DIVU producing LO=quotient, HI=remainder; DIV_ZERO_FAST_EN skips CALC on a zero divisor.
// Latency: valid pulses 33 cycles after start (1 cycle for zero divisor when DIV_ZERO_FAST_EN is defined).
// Backpressure: none; busy stalls the pipeline, start is ignored outside IDLE, cancel aborts without writing HI/LO.
module div_unit #(
    parameter int DIV_W = 32
) (
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  div_if
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [5:0] LAST_ITER = 6'(DIV_W - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_cnt;
    logic [DIV_W-1:0] r_rem;
    logic [DIV_W-1:0] r_quo;
    logic [DIV_W-1:0] r_dvs;
    logic [DIV_W-1:0] r_a;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [DIV_W-1:0] r_hi;
    logic [DIV_W-1:0] r_lo;

    logic             w_busy;
    logic             w_valid;
    logic             w_accept;
    logic [DIV_W-1:0] w_a_mag;
    logic [DIV_W-1:0] w_b_mag;
    logic [DIV_W:0]   w_shift;
    logic [DIV_W:0]   w_diff;
    logic [DIV_W-1:0] w_q_fix;
    logic [DIV_W-1:0] w_r_fix;

    assign w_accept = (r_state == S_IDLE) && div_if.div_start && !div_if.div_cancel;
    assign w_a_mag  = (div_if.div_signed && div_if.div_a[DIV_W-1]) ? -div_if.div_a : div_if.div_a;
    assign w_b_mag  = (div_if.div_signed && div_if.div_b[DIV_W-1]) ? -div_if.div_b : div_if.div_b;

    // The shifted remainder can reach 2*divisor-1, hence the 33-bit trial subtract.
    assign w_shift  = {r_rem, r_quo[DIV_W-1]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_q_fix  = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix  = r_neg_r ? -r_rem : r_rem;

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
                    w_state_nxt = (div_if.div_b == '0) ? S_FIX : S_CALC;
`else
                    w_state_nxt = S_CALC;
`endif
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_ITER) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_busy      = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_valid     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (div_if.div_cancel) begin
            w_state_nxt = S_IDLE;
            w_valid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_a     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (!div_if.div_cancel) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_a     <= div_if.div_a;
                        r_neg_q <= div_if.div_signed && (div_if.div_a[DIV_W-1] ^ div_if.div_b[DIV_W-1]);
                        r_neg_r <= div_if.div_signed && div_if.div_a[DIV_W-1];
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (!w_diff[DIV_W]) begin
                        r_rem <= w_diff[DIV_W-1:0];
                        r_quo <= {r_quo[DIV_W-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[DIV_W-1:0];
                        r_quo <= {r_quo[DIV_W-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    // A zero divisor has a zero magnitude in either mode.
                    if (r_dvs == '0) begin
                        r_lo <= '1;
                        r_hi <= r_a;
                    end else begin
                        r_lo <= w_q_fix;
                        r_hi <= w_r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_if.div_busy  = w_busy;
    assign div_if.div_valid = w_valid;
    assign div_if.div_hi    = r_hi;
    assign div_if.div_lo    = r_lo;
endmodule

// File: tb/tb_div_unit.sv
// Directed plus randomized checks of div_unit against an arithmetic reference of DIV/DIVU semantics.
module tb_div_unit;
    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_fail;

    div_unit_if #(.DIV_W(32)) u_if ();

    div_unit #(.DIV_W(32)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .div_if (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {hi, lo} from plain signed/unsigned arithmetic.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] qv;
        logic [63:0] rv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            qv = q;
            rv = r;
            return {rv[31:0], qv[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 32'd0) ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    function automatic int exp_busy(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 32'd0) ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    task automatic run_chk(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                           input bit glitch, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        int bcnt;
        @(negedge clk);
        u_if.div_a      = a;
        u_if.div_b      = b;
        u_if.div_signed = s;
        u_if.div_start  = 1'b1;
        @(posedge clk);
        #1;
        u_if.div_start  = 1'b0;
        u_if.div_a      = $urandom;
        u_if.div_b      = $urandom;
        u_if.div_signed = 1'($urandom);
        bcnt = u_if.div_busy ? 1 : 0;
        lat  = -1;
        for (int i = 1; i <= 60; i++) begin
            if (glitch) u_if.div_start = (i == 5 || i == 15);
            @(posedge clk);
            #1;
            if (u_if.div_valid) begin
                lat = i;
                break;
            end
            if (u_if.div_busy) bcnt++;
        end
        u_if.div_start = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat(b)));
        check({tag, " busy cycles"}, 32'(bcnt), 32'(exp_busy(b)));
        check({tag, " lo"}, u_if.div_lo, exp_lo);
        check({tag, " hi"}, u_if.div_hi, exp_hi);
        @(posedge clk);
        #1;
        check({tag, " valid pulse width"}, 32'(u_if.div_valid), 32'd0);
        check({tag, " lo hold"}, u_if.div_lo, exp_lo);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] m;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int          vseen;

        n_cmp  = 0;
        n_fail = 0;
        resetn          = 1'b0;
        u_if.div_start  = 1'b0;
        u_if.div_signed = 1'b0;
        u_if.div_a      = '0;
        u_if.div_b      = '0;
        u_if.div_cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(u_if.div_busy), 32'd0);
        check("reset valid", 32'(u_if.div_valid), 32'd0);
        check("reset hi", u_if.div_hi, 32'd0);
        check("reset lo", u_if.div_lo, 32'd0);
        resetn = 1'b1;

        run_chk("divu 100/7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd2, 32'd14);
        run_chk("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_chk("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'd1, 32'hFFFF_FFFD);
        run_chk("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 32'h8000_0000);
        run_chk("divu max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF);
        run_chk("divu by 0", 32'h1234, 32'd0, 1'b0, 1'b0, 32'h1234, 32'hFFFF_FFFF);
        run_chk("div by 0", 32'h1234, 32'd0, 1'b1, 1'b0, 32'h1234, 32'hFFFF_FFFF);

        // Cancel in CALC: no result, outputs untouched.
        prev_hi = u_if.div_hi;
        prev_lo = u_if.div_lo;
        @(negedge clk);
        u_if.div_a = 32'd100; u_if.div_b = 32'd7; u_if.div_signed = 1'b0; u_if.div_start = 1'b1;
        @(posedge clk);
        #1;
        u_if.div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        u_if.div_cancel = 1'b1;
        @(posedge clk);
        #1;
        u_if.div_cancel = 1'b0;
        check("cancel busy", 32'(u_if.div_busy), 32'd0);
        vseen = u_if.div_valid ? 1 : 0;
        @(posedge clk);
        #1;
        if (u_if.div_valid) vseen++;
        check("cancel no valid", 32'(vseen), 32'd0);
        check("cancel hi kept", u_if.div_hi, prev_hi);
        check("cancel lo kept", u_if.div_lo, prev_lo);
        run_chk("after cancel 9/3", 32'd9, 32'd3, 1'b0, 1'b0, 32'd0, 32'd3);

        // Cancel and start together: request is dropped.
        @(negedge clk);
        u_if.div_a = 32'd50; u_if.div_b = 32'd5; u_if.div_start = 1'b1; u_if.div_cancel = 1'b1;
        @(posedge clk);
        #1;
        u_if.div_start = 1'b0;
        u_if.div_cancel = 1'b0;
        check("cancel+start busy", 32'(u_if.div_busy), 32'd0);
        vseen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (u_if.div_valid || u_if.div_busy) vseen++;
        end
        check("cancel+start idle", 32'(vseen), 32'd0);

        // Reset in the middle of CALC.
        @(negedge clk);
        u_if.div_a = 32'd1000; u_if.div_b = 32'd3; u_if.div_signed = 1'b0; u_if.div_start = 1'b1;
        @(posedge clk);
        #1;
        u_if.div_start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("midreset busy", 32'(u_if.div_busy), 32'd0);
        check("midreset valid", 32'(u_if.div_valid), 32'd0);
        check("midreset hi", u_if.div_hi, 32'd0);
        check("midreset lo", u_if.div_lo, 32'd0);

        run_chk("start ignored in calc", 32'd1000, 32'd9, 1'b0, 1'b1, 32'd1, 32'd111);

        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                4: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            m = ref_div(a, b, s);
            run_chk($sformatf("rand%0d %h/%h s%0d", k, a, b, s), a, b, s, (b != 32'd0), m[63:32], m[31:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
